// File: rtl/dfd_tt_dbm_pkg.sv
// Shared types and constants for the second-generation debug bus mux.
//   dbm_mode_e    : output source modes selected by a WR_MODE transfer
//   dbm_cfg_op_e  : opcodes on the serial config port
//   dbm_state_e   : IDLE / SETTLE / ACTIVE control state
//   DBM_LFSR_*    : seed and tap mask of the 16-bit pattern LFSR
package dfd_tt_dbm_pkg;

    typedef enum logic [2:0] {
        DBM_MODE_OFF    = 3'd0,
        DBM_MODE_FUNC   = 3'd1,
        DBM_MODE_ID     = 3'd2,
        DBM_MODE_TOGGLE = 3'd3,
        DBM_MODE_WALK   = 3'd4,
        DBM_MODE_LFSR   = 3'd5,
        DBM_MODE_FREEZE = 3'd6,
        DBM_MODE_RSVD   = 3'd7
    } dbm_mode_e;

    typedef enum logic [1:0] {
        DBM_OP_WR_MODE = 2'd0,
        DBM_OP_WR_SEL  = 2'd1,
        DBM_OP_COMMIT  = 2'd2,
        DBM_OP_RSVD    = 2'd3
    } dbm_cfg_op_e;

    typedef enum logic [1:0] {
        DBM_IDLE   = 2'd0,
        DBM_SETTLE = 2'd1,
        DBM_ACTIVE = 2'd2
    } dbm_state_e;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: the new MSB is
    // the XOR of bits 0, 2, 3 and 5 of the current state.
    localparam logic [15:0] DBM_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DBM_LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] dbm_lfsr_next(input logic [15:0] s);
        return {^(s & DBM_LFSR_TAPS), s[15:1]};
    endfunction

    // Code 7 is folded onto OFF so that "mode changed" compares are exact.
    function automatic dbm_mode_e dbm_norm_mode(input logic [2:0] code);
        if (code == 3'd7) begin
            return DBM_MODE_OFF;
        end
        return dbm_mode_e'(code);
    endfunction

endpackage

// File: rtl/dfd_tt_dbm_pattern_gen.sv
// Built-in pattern sources for the debug bus mux: ID, TOGGLE, WALK, LFSR.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   mode       : current DBM mode (dbm_mode_e encoding)
//   active     : high during ACTIVE cycles; generators advance only then
//   restart    : returns every generator to its start value
//   pattern    : W-bit pattern for the current mode, 0 for non-pattern modes
module dfd_tt_dbm_pattern_gen
    import dfd_tt_dbm_pkg::*;
#(
    parameter int W          = 64,
    parameter int LANE_WIDTH = 8,
    parameter int ID_VALUE   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   mode,
    input  logic         active,
    input  logic         restart,
    output logic [W-1:0] pattern
);

    logic [W-1:0] id_pattern;
    logic [W-1:0] lfsr_wide;
    logic [W-1:0] walk_reg;
    logic [15:0]  lfsr_reg;
    logic         toggle_reg;

    always_comb begin
        id_pattern = '0;
        id_pattern[LANE_WIDTH-1:0] = LANE_WIDTH'(ID_VALUE);
    end

    // LFSR state replicated across the bus; the top copy is truncated.
    for (genvar gi = 0; gi < W; gi++) begin : g_lfsr_rep
        assign lfsr_wide[gi] = lfsr_reg[gi % 16];
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            toggle_reg <= 1'b0;
            walk_reg   <= W'(1);
            lfsr_reg   <= DBM_LFSR_SEED;
        end else if (active) begin
            case (mode)
                DBM_MODE_TOGGLE: toggle_reg <= ~toggle_reg;
                DBM_MODE_WALK:   walk_reg   <= {walk_reg[W-2:0], walk_reg[W-1]};
                DBM_MODE_LFSR:   lfsr_reg   <= dbm_lfsr_next(lfsr_reg);
                default: ;
            endcase
        end
    end

    always_comb begin
        pattern = '0;
        case (mode)
            DBM_MODE_ID:     pattern = id_pattern;
            DBM_MODE_TOGGLE: pattern = toggle_reg ? ~id_pattern : id_pattern;
            DBM_MODE_WALK:   pattern = walk_reg;
            DBM_MODE_LFSR:   pattern = lfsr_wide;
            default:         pattern = '0;
        endcase
    end

endmodule

// File: rtl/dfd_tt_debug_bus_mux_gen2.sv
// Second-generation debug bus mux. Selects NUM_OUTPUT_LANES lanes out of
// NUM_INPUT_LANES onto the debug bus, or drives a built-in pattern, through a
// PIPE_STAGES-deep output register chain with a parallel valid chain.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   cfg_valid/ready   : config handshake (transfer on valid & ready)
//   cfg_id            : target DBM ID; other IDs complete with no effect
//   cfg_op            : WR_MODE / WR_SEL / COMMIT / reserved
//   cfg_lane          : output lane for WR_SEL
//   cfg_data          : mode in [2:0] or lane select in [SEL_WIDTH-1:0]
//   debug_signals_in  : input lanes
//   debug_bus_out     : debug bus
//   debug_bus_valid   : bus carries settled data for the current mode
//   debug_clken       : clock enable for upstream tap flops
module dfd_tt_debug_bus_mux_gen2
    import dfd_tt_dbm_pkg::*;
#(
    parameter int LANE_WIDTH       = 8,
    parameter int NUM_INPUT_LANES  = 16,
    parameter int NUM_OUTPUT_LANES = 8,
    parameter int DEBUG_MUX_ID     = 0,
    parameter int ID_WIDTH         = 6,
    parameter int PIPE_STAGES      = 1,
    localparam int SEL_WIDTH = ($clog2(NUM_INPUT_LANES-NUM_OUTPUT_LANES+1) > 1) ?
                               $clog2(NUM_INPUT_LANES-NUM_OUTPUT_LANES+1) : 1,
    localparam int LANE_IDX_W = ($clog2(NUM_OUTPUT_LANES) > 1) ? $clog2(NUM_OUTPUT_LANES) : 1,
    localparam int W          = LANE_WIDTH*NUM_OUTPUT_LANES
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [ID_WIDTH-1:0]                   cfg_id,
    input  logic [1:0]                            cfg_op,
    input  logic [LANE_IDX_W-1:0]                 cfg_lane,
    input  logic [7:0]                            cfg_data,
    input  logic [NUM_INPUT_LANES*LANE_WIDTH-1:0] debug_signals_in,
    output logic [W-1:0]                          debug_bus_out,
    output logic                                  debug_bus_valid,
    output logic                                  debug_clken
);

    localparam int EXTRA_LANES = NUM_INPUT_LANES - NUM_OUTPUT_LANES;
    // cfg_ready stays low for the SETTLE cycle plus the pipeline fill.
    localparam logic [2:0] BUSY_LOAD = 3'(PIPE_STAGES + 1);

    dbm_mode_e      mode_reg;
    dbm_mode_e      new_mode;
    dbm_state_e     state_reg;
    dbm_state_e     state_next;
    logic [2:0]     busy_cnt_reg;
    logic [SEL_WIDTH-1:0] shadow_sel_reg [NUM_OUTPUT_LANES];
    logic [SEL_WIDTH-1:0] active_sel_reg [NUM_OUTPUT_LANES];

    logic           xfer;
    logic           hit;
    logic           mode_change;
    logic           sel_write;
    logic           commit;
    logic           src_enable;
    logic           src_valid;
    logic [W-1:0]   func_bus;
    logic [W-1:0]   pattern;
    logic [W-1:0]   src_data;
    logic           cfg_data_unused;

    // ---------------- config decode ----------------
    assign cfg_ready   = (busy_cnt_reg == 3'd0);
    assign xfer        = cfg_valid && cfg_ready;
    assign hit         = xfer && (cfg_id == ID_WIDTH'(DEBUG_MUX_ID));
    assign new_mode    = dbm_norm_mode(cfg_data[2:0]);
    assign mode_change = hit && (cfg_op == DBM_OP_WR_MODE) && (new_mode != mode_reg);
    assign sel_write   = hit && (cfg_op == DBM_OP_WR_SEL);
    assign commit      = hit && (cfg_op == DBM_OP_COMMIT);
    assign cfg_data_unused = ^cfg_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg     <= DBM_MODE_OFF;
            busy_cnt_reg <= 3'd0;
        end else begin
            if (mode_change) begin
                mode_reg     <= new_mode;
                busy_cnt_reg <= BUSY_LOAD;
            end else if (busy_cnt_reg != 3'd0) begin
                busy_cnt_reg <= busy_cnt_reg - 3'd1;
            end
        end
    end

    // Shadow selects are written freely; COMMIT moves all of them at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < NUM_OUTPUT_LANES; l++) begin
                shadow_sel_reg[l] <= '0;
                active_sel_reg[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_OUTPUT_LANES; l++) begin
                if (sel_write && (cfg_lane == LANE_IDX_W'(l))) begin
                    shadow_sel_reg[l] <= cfg_data[SEL_WIDTH-1:0];
                end
                if (commit) begin
                    active_sel_reg[l] <= shadow_sel_reg[l];
                end
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DBM_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (mode_change) begin
            state_next = DBM_SETTLE;
        end else begin
            case (state_reg)
                DBM_SETTLE: state_next = (mode_reg == DBM_MODE_OFF) ? DBM_IDLE : DBM_ACTIVE;
                default:    state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        src_enable = 1'b0;
        src_valid  = 1'b0;
        case (state_reg)
            DBM_ACTIVE: begin
                src_enable = 1'b1;
                src_valid  = (mode_reg inside {DBM_MODE_FUNC, DBM_MODE_ID, DBM_MODE_TOGGLE,
                                               DBM_MODE_WALK, DBM_MODE_LFSR});
            end
            default: ;
        endcase
    end

    assign debug_clken = (mode_reg != DBM_MODE_OFF);

    // ---------------- lane mux ----------------
    // sel 0 keeps the lane's own input; sel n picks from the extra lanes above
    // the output count; anything past the last extra lane drives zero.
    for (genvar gi = 0; gi < NUM_OUTPUT_LANES; gi++) begin : g_lane
        logic [LANE_WIDTH-1:0] lane_val;
        always_comb begin
            lane_val = '0;
            if (active_sel_reg[gi] == '0) begin
                lane_val = debug_signals_in[gi*LANE_WIDTH +: LANE_WIDTH];
            end else begin
                for (int n = 1; n <= EXTRA_LANES; n++) begin
                    if (active_sel_reg[gi] == SEL_WIDTH'(n)) begin
                        lane_val = debug_signals_in[(NUM_OUTPUT_LANES+n-1)*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
        assign func_bus[gi*LANE_WIDTH +: LANE_WIDTH] = lane_val;
    end

    dfd_tt_dbm_pattern_gen #(
        .W          (W),
        .LANE_WIDTH (LANE_WIDTH),
        .ID_VALUE   (DEBUG_MUX_ID)
    ) u_pattern_gen (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode_reg),
        .active  (src_enable),
        .restart (mode_change),
        .pattern (pattern)
    );

    // SETTLE, IDLE and OFF all force a zero source.
    always_comb begin
        src_data = '0;
        if (src_enable) begin
            case (mode_reg)
                DBM_MODE_FUNC: src_data = func_bus;
                DBM_MODE_ID, DBM_MODE_TOGGLE, DBM_MODE_WALK, DBM_MODE_LFSR: src_data = pattern;
                default:       src_data = '0;
            endcase
        end
    end

    // ---------------- output pipeline ----------------
    // In FREEZE the first stage holds both data and valid, so a freeze entered
    // from FUNC keeps presenting the last captured sample as valid data.
    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
        logic [W-1:0] data_reg;
        logic         valid_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (mode_reg != DBM_MODE_FREEZE) begin
                    data_reg  <= src_data;
                    valid_reg <= src_valid;
                end
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    data_reg  <= g_stage[gi-1].data_reg;
                    valid_reg <= g_stage[gi-1].valid_reg;
                end
            end
        end
    end

    assign debug_bus_out   = g_stage[PIPE_STAGES-1].data_reg;
    assign debug_bus_valid = g_stage[PIPE_STAGES-1].valid_reg;

endmodule

// File: tb/tb_dfd_tt_debug_bus_mux_gen2.sv
// Scoreboard bench for dfd_tt_debug_bus_mux_gen2 (8 lanes of 8 bits out of
// 16, ID 6'h2A, one pipeline stage). Stimulus pushes cycle-stamped expected
// values; a negedge monitor pops and compares them.
module tb_dfd_tt_debug_bus_mux_gen2;

    localparam int LW   = 8;
    localparam int NIN  = 16;
    localparam int NOUT = 8;
    localparam logic [5:0] MY_ID    = 6'h2A;
    localparam logic [5:0] OTHER_ID = 6'h15;
    localparam logic [1:0] OP_WR_MODE = 2'd0;
    localparam logic [1:0] OP_WR_SEL  = 2'd1;
    localparam logic [1:0] OP_COMMIT  = 2'd2;
    localparam logic [7:0] M_OFF = 8'd0, M_FUNC = 8'd1, M_TOGGLE = 8'd3,
                           M_WALK = 8'd4, M_LFSR = 8'd5, M_FREEZE = 8'd6;
    localparam logic [127:0] D1 = 128'hF0E1D2C3B4A59687_78695A4B3C2D1E0F;
    localparam logic [127:0] D2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] D3 = 128'hDEADBEEFCAFEF00D_0BADC0DE12345678;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [5:0]    cfg_id;
    logic [1:0]    cfg_op;
    logic [2:0]    cfg_lane;
    logic [7:0]    cfg_data;
    logic [127:0]  din;
    logic [63:0]   bus;
    logic          bus_valid;
    logic          clken;

    dfd_tt_debug_bus_mux_gen2 #(
        .LANE_WIDTH       (LW),
        .NUM_INPUT_LANES  (NIN),
        .NUM_OUTPUT_LANES (NOUT),
        .DEBUG_MUX_ID     (42),
        .ID_WIDTH         (6),
        .PIPE_STAGES      (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_id           (cfg_id),
        .cfg_op           (cfg_op),
        .cfg_lane         (cfg_lane),
        .cfg_data         (cfg_data),
        .debug_signals_in (din),
        .debug_bus_out    (bus),
        .debug_bus_valid  (bus_valid),
        .debug_clken      (clken)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int tb_sel [NOUT];

    // Scoreboard: parallel queues, one entry per expected observation.
    // -1 in valid/ready/clken means "not checked".
    int          q_cyc   [$];
    string       q_name  [$];
    int          q_chkbus[$];
    logic [63:0] q_bus   [$];
    int          q_valid [$];
    int          q_ready [$];
    int          q_clken [$];

    task automatic push(input int at, input string nm, input int cb, input logic [63:0] b,
                        input int v, input int r, input int c);
        q_cyc.push_back(at);
        q_name.push_back(nm);
        q_chkbus.push_back(cb);
        q_bus.push_back(b);
        q_valid.push_back(v);
        q_ready.push_back(r);
        q_clken.push_back(c);
    endtask

    function automatic logic [63:0] func_model(input logic [127:0] d);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < NOUT; l++) begin
            int s;
            s = tb_sel[l];
            if (s == 0) r[l*LW +: LW] = d[l*LW +: LW];
            else if (s <= NIN - NOUT) r[l*LW +: LW] = d[(NOUT+s-1)*LW +: LW];
        end
        return r;
    endfunction

    // Monitor
    int          m_cyc, m_cb, m_v, m_r, m_c, m_bad;
    string       m_nm;
    logic [63:0] m_bus;
    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            m_cyc = q_cyc.pop_front();
            m_nm  = q_name.pop_front();
            m_cb  = q_chkbus.pop_front();
            m_bus = q_bus.pop_front();
            m_v   = q_valid.pop_front();
            m_r   = q_ready.pop_front();
            m_c   = q_clken.pop_front();
            m_bad = 0;
            if (m_cyc < cyc) begin
                checks++; errors++; m_bad = 1;
                $display("FAIL %s stale entry: due cyc %0d, now cyc %0d", m_nm, m_cyc, cyc);
            end else begin
                if (m_cb != 0) begin
                    checks++;
                    if (bus !== m_bus) begin
                        errors++; m_bad = 1;
                        $display("FAIL %s bus got %h want %h (cyc %0d)", m_nm, bus, m_bus, cyc);
                    end
                end
                if (m_v >= 0) begin
                    checks++;
                    if (bus_valid !== m_v[0]) begin
                        errors++; m_bad = 1;
                        $display("FAIL %s valid got %b want %0d (cyc %0d)", m_nm, bus_valid, m_v, cyc);
                    end
                end
                if (m_r >= 0) begin
                    checks++;
                    if (cfg_ready !== m_r[0]) begin
                        errors++; m_bad = 1;
                        $display("FAIL %s cfg_ready got %b want %0d (cyc %0d)", m_nm, cfg_ready, m_r, cyc);
                    end
                end
                if (m_c >= 0) begin
                    checks++;
                    if (clken !== m_c[0]) begin
                        errors++; m_bad = 1;
                        $display("FAIL %s clken got %b want %0d (cyc %0d)", m_nm, clken, m_c, cyc);
                    end
                end
                if (m_bad == 0) $display("check %s cyc %0d bus %h valid %b ok", m_nm, cyc, bus, bus_valid);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One config transfer; returns the cycle number just after acceptance.
    task automatic cfg_xfer(input logic [5:0] id, input logic [1:0] op, input logic [2:0] lane,
                            input logic [7:0] data, output int acc);
        int n;
        n = 0;
        cfg_id = id; cfg_op = op; cfg_lane = lane; cfg_data = data; cfg_valid = 1'b1;
        @(negedge clk);
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            checks++; errors++;
            $display("FAIL cfg_xfer_timeout got ready=0 want ready=1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        acc = cyc;
        $display("xfer id %h op %0d lane %0d data %h accepted, now cyc %0d", id, op, lane, data, acc);
    endtask

    initial begin
        int e, e2, p;
        logic [63:0] old_exp, new_exp, frz_exp;
        for (int l = 0; l < NOUT; l++) tb_sel[l] = 0;
        reset = 1'b1; cfg_valid = 1'b0; cfg_id = '0; cfg_op = '0; cfg_lane = '0; cfg_data = '0;
        din = D1;

        // Reset state.
        push(1, "reset_state", 1, 64'h0, 0, 1, 0);
        wait_cycles(3);
        reset = 1'b0;

        // FUNC with default selects.
        cfg_xfer(MY_ID, OP_WR_MODE, 3'd0, M_FUNC, e);
        push(e,   "func_settle", 0, 64'h0, 0, 0, 1);
        push(e+1, "func_fill",   0, 64'h0, 0, 0, 1);
        push(e+2, "func_first",  1, D1[63:0], 1, 1, 1);
        wait_cycles(3);

        // Shadow writes leave the output alone; COMMIT applies them.
        old_exp = func_model(D1);
        cfg_xfer(MY_ID, OP_WR_SEL, 3'd3, 8'd8, e);
        cfg_xfer(MY_ID, OP_WR_SEL, 3'd5, 8'd9, e);
        push(e, "shadow_no_effect", 1, old_exp, 1, 1, -1);
        cfg_xfer(MY_ID, OP_COMMIT, 3'd0, 8'd0, e);
        tb_sel[3] = 8; tb_sel[5] = 9;
        new_exp = func_model(D1);
        push(e,   "commit_old", 1, old_exp, 1, 1, -1);
        push(e+1, "commit_new", 1, new_exp, 1, 1, -1);
        push(e+1, "commit_hand", 1, {D1[63:48], 8'h00, D1[39:32], D1[127:120], D1[23:0]}, -1, -1, -1);
        wait_cycles(2);

        // FUNC latency of one stage.
        p = cyc;
        din = D2;
        push(p,   "lat_before", 1, func_model(D1), 1, -1, -1);
        push(p+1, "lat_after",  1, func_model(D2), 1, -1, -1);
        wait_cycles(2);

        // Mismatched ID: completes, no effect.
        cfg_xfer(OTHER_ID, OP_WR_MODE, 3'd0, M_TOGGLE, e);
        push(e,   "wrong_id_0", 1, func_model(D2), 1, 1, 1);
        push(e+1, "wrong_id_1", 1, func_model(D2), 1, 1, 1);
        wait_cycles(3);

        // TOGGLE.
        cfg_xfer(MY_ID, OP_WR_MODE, 3'd0, M_TOGGLE, e);
        push(e+1, "toggle_fill", 0, 64'h0, 0, 0, 1);
        push(e+2, "toggle_0", 1, 64'h0000_0000_0000_002A, 1, 1, -1);
        push(e+3, "toggle_1", 1, 64'hFFFF_FFFF_FFFF_FFD5, 1, 1, -1);
        push(e+4, "toggle_2", 1, 64'h0000_0000_0000_002A, 1, 1, -1);
        wait_cycles(6);

        // WALK.
        cfg_xfer(MY_ID, OP_WR_MODE, 3'd0, M_WALK, e);
        push(e+2,  "walk_bit0",  1, 64'h0000_0000_0000_0001, 1, -1, -1);
        push(e+3,  "walk_bit1",  1, 64'h0000_0000_0000_0002, 1, -1, -1);
        push(e+65, "walk_bit63", 1, 64'h8000_0000_0000_0000, 1, -1, -1);
        push(e+66, "walk_wrap",  1, 64'h0000_0000_0000_0001, 1, -1, -1);
        wait_cycles(70);

        // LFSR.
        cfg_xfer(MY_ID, OP_WR_MODE, 3'd0, M_LFSR, e);
        push(e+2, "lfsr_0", 1, {4{16'hACE1}}, 1, -1, -1);
        push(e+3, "lfsr_1", 1, {4{16'h5670}}, 1, -1, -1);
        push(e+4, "lfsr_2", 1, {4{16'hAB38}}, 1, -1, -1);
        push(e+5, "lfsr_3", 1, {4{16'h559C}}, 1, -1, -1);
        wait_cycles(8);

        // FREEZE from FUNC, inputs scrambled afterwards.
        cfg_xfer(MY_ID, OP_WR_MODE, 3'd0, M_FUNC, e);
        wait_cycles(3);
        din = D3;
        wait_cycles(2);
        frz_exp = func_model(D3);
        push(cyc, "pre_freeze", 1, frz_exp, 1, 1, -1);
        wait_cycles(1);
        cfg_xfer(MY_ID, OP_WR_MODE, 3'd0, M_FREEZE, e2);
        for (int k = 0; k < 4; k++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            push(e2 + k, "freeze_hold", 1, frz_exp, 1, -1, 1);
            wait_cycles(1);
        end
        wait_cycles(3);

        // Reset in the middle of SETTLE.
        cfg_xfer(MY_ID, OP_WR_MODE, 3'd0, M_WALK, e);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        push(e+1, "settle_reset", 1, 64'h0, 0, 1, 0);
        wait_cycles(3);
        push(cyc, "idle_after_reset", 1, 64'h0, 0, 1, 0);
        wait_cycles(1);

        // Selects cleared by reset.
        for (int l = 0; l < NOUT; l++) tb_sel[l] = 0;
        din = D1;
        cfg_xfer(MY_ID, OP_WR_MODE, 3'd0, M_FUNC, e);
        push(e+2, "func_after_reset", 1, func_model(D1), 1, 1, 1);

        // Drain the scoreboard with a bounded wait.
        begin
            int n;
            n = 0;
            while (q_cyc.size() > 0 && n < 300) begin
                @(posedge clk);
                n++;
            end
        end
        while (q_cyc.size() > 0) begin
            checks++; errors++;
            $display("FAIL %s never observed: due cyc %0d, now cyc %0d", q_name[0], q_cyc[0], cyc);
            void'(q_cyc.pop_front());
            void'(q_name.pop_front());
            void'(q_chkbus.pop_front());
            void'(q_bus.pop_front());
            void'(q_valid.pop_front());
            void'(q_ready.pop_front());
            void'(q_clken.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
